// File: rtl/cpu_pkg.sv
// Shared types for the fetch slice: opcodes, fetch FSM states and the prefetch queue entry.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_AND   = 4'h2,
    OP_OR    = 4'h3,
    OP_XOR   = 4'h4,
    OP_SHL   = 4'h5,
    OP_SHR   = 4'h6,
    OP_LDI   = 4'h7,
    OP_LD    = 4'h8,
    OP_ST    = 4'h9,
    OP_BEQ   = 4'hA,
    OP_BNE   = 4'hB,
    OP_JMP   = 4'hC,
    OP_CALL  = 4'hD,
    OP_RET   = 4'hE,
    OP_FLUSH = 4'hF
  } opcode_e;

  localparam logic [15:0] NOP_INSTR = 16'hF000;

  typedef enum logic [1:0] {
    F_IDLE,
    F_WAIT,
    F_SQUASH
  } fetch_state_e;

  typedef struct packed {
    logic [15:0] pc_inc;
    logic [15:0] instr;
  } fq_entry_t;

  localparam fq_entry_t BUBBLE = '{pc_inc: 16'h0000, instr: NOP_INSTR};

  // CALL target keeps the caller's 4K page and replaces the low 12 bits.
  function automatic logic [15:0] call_target(input fq_entry_t e);
    return {e.pc_inc[15:12], e.instr[11:0]};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO (power-of-2 depth) with synchronous clear and async active-high reset.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          clear_i,
  input  fq_entry_t     push_data_i,
  output fq_entry_t     head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int AW = $clog2(DEPTH);

  fq_entry_t     mem_q [DEPTH];
  logic [AW-1:0] rd_q;
  logic [AW-1:0] wr_q;
  logic [CW-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
      if (push_i && !pop_i)      count_q <= count_q + 1'b1;
      else if (pop_i && !push_i) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/if_slice.sv
// Instruction-fetch stage: single-outstanding imem fetch, prefetch queue, decode output register.
// Optional CALL predecode self-redirect is enabled by defining IF_CALL_PREDECODE_EN.
module if_slice
  import cpu_pkg::*;
#(
  parameter int          FQ_DEPTH = 2,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  output logic [15:0] PC_inc,
  output logic [15:0] instr,
  output logic        instr_valid
`ifdef IF_CALL_PREDECODE_EN
  ,
  output logic        call_predicted
`endif
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [15:0]   fetch_pc_q, fetch_pc_d;
  fq_entry_t     out_q, out_d;
  logic          valid_q, valid_d;
  fq_entry_t     push_e, pop_e, q_head;
  logic          push_v, pop_fire, predict;
  logic          q_push, q_pop, q_clear, q_full, q_empty;
  logic [CW-1:0] q_count;

  fetch_queue #(.DEPTH(FQ_DEPTH), .CW(CW)) u_fq (
    .clk        (clk),
    .rst        (rst),
    .push_i     (q_push),
    .pop_i      (q_pop),
    .clear_i    (q_clear),
    .push_data_i(push_e),
    .head_o     (q_head),
    .count_o    (q_count),
    .full_o     (q_full),
    .empty_o    (q_empty)
  );

  always_comb begin
    push_e   = '{pc_inc: fetch_pc_q + 16'd1, instr: imem_rdata};
    push_v   = (state_q == F_WAIT) && imem_rvalid && !redirect;
    // An empty queue lets the arriving word fall straight through to the output.
    pop_e    = q_empty ? push_e : q_head;
    pop_fire = !redirect && !flush && !stall && (!q_empty || push_v);
`ifdef IF_CALL_PREDECODE_EN
    predict  = pop_fire && (pop_e.instr[15:12] == OP_CALL);
`else
    predict  = 1'b0;
`endif
    q_pop    = pop_fire && !q_empty;
    q_push   = push_v && !q_full && !(pop_fire && q_empty);
    q_clear  = redirect || predict;
    imem_req = !rst && (state_q == F_IDLE) && (q_count < CW'(FQ_DEPTH))
               && !redirect && !predict;

    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    unique case (state_q)
      F_IDLE:   if (imem_req && imem_gnt) state_d = F_WAIT;
      F_WAIT: begin
        if (imem_rvalid) begin
          state_d    = F_IDLE;
          fetch_pc_d = push_e.pc_inc;
        end else if (redirect || predict) begin
          state_d = F_SQUASH;
        end
      end
      F_SQUASH: if (imem_rvalid) state_d = F_IDLE;
      default:  state_d = F_IDLE;
    endcase
    if (predict)  fetch_pc_d = call_target(pop_e);
    if (redirect) fetch_pc_d = redirect_pc;

    out_d   = out_q;
    valid_d = valid_q;
    if (redirect || flush) begin
      out_d   = BUBBLE;
      valid_d = 1'b0;
    end else if (!stall) begin
      out_d   = pop_fire ? pop_e : BUBBLE;
      valid_d = pop_fire;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= F_IDLE;
      fetch_pc_q <= RESET_PC;
      out_q      <= BUBBLE;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      out_q      <= out_d;
      valid_q    <= valid_d;
    end
  end

`ifdef IF_CALL_PREDECODE_EN
  logic call_q, call_d;

  always_comb begin
    call_d = call_q;
    if (redirect || flush) call_d = 1'b0;
    else if (!stall)       call_d = predict;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) call_q <= 1'b0;
    else     call_q <= call_d;
  end

  assign call_predicted = call_q;
`endif

  assign imem_addr   = fetch_pc_q;
  assign PC_inc      = out_q.pc_inc;
  assign instr       = out_q.instr;
  assign instr_valid = valid_q;

endmodule

// File: tb/tb_if_slice.sv
// Directed bench for if_slice with a variable-latency instruction memory model.
module tb_if_slice;

  logic        clk = 1'b0;
  logic        rst, stall, flush, redirect;
  logic [15:0] redirect_pc;
  logic        imem_req, imem_gnt;
  logic [15:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [15:0] imem_rdata  = 16'h0000;
  logic [15:0] PC_inc, instr;
  logic        instr_valid;
`ifdef IF_CALL_PREDECODE_EN
  logic        call_predicted;
`endif

  int          errors = 0;
  int          checks = 0;
  int          lat    = 1;
  logic        gnt_en = 1'b0;
  logic        pend   = 1'b0;
  int          cnt    = 0;
  logic [15:0] paddr  = 16'h0000;
  int          gcnt   = 0;
  int          g0;

  if_slice #(.FQ_DEPTH(2), .RESET_PC(16'h0010)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .PC_inc        (PC_inc),
    .instr         (instr),
    .instr_valid   (instr_valid)
`ifdef IF_CALL_PREDECODE_EN
    ,
    .call_predicted(call_predicted)
`endif
  );

  always #5 clk = ~clk;
  assign imem_gnt = gnt_en;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0010: return 16'h0123;
      16'h0100: return 16'hAAAA;
      16'h2000: return 16'hD345;
      default:  return {4'h1, a[11:0]};
    endcase
  endfunction

  // Memory answers in order, lat cycles after the grant.
  always @(posedge clk) begin
    imem_rvalid <= 1'b0;
    if (pend) begin
      if (cnt <= 1) begin
        imem_rvalid <= 1'b1;
        imem_rdata  <= mem_word(paddr);
        pend        <= 1'b0;
      end else begin
        cnt <= cnt - 1;
      end
    end
    if (imem_req && imem_gnt) begin
      gcnt <= gcnt + 1;
      if (lat <= 1) begin
        imem_rvalid <= 1'b1;
        imem_rdata  <= mem_word(imem_addr);
      end else begin
        pend  <= 1'b1;
        cnt   <= lat - 1;
        paddr <= imem_addr;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic quiesce();
    bit done;
    done   = 1'b0;
    gnt_en = 1'b0;
    stall  = 1'b0;
    flush  = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (!pend && !imem_rvalid) done = 1'b1;
    end
    chk("quiesce_done", 32'(done), 32'd1);
  endtask

  // Called at a negedge; returns at the next negedge with redirect released.
  task automatic redirect_to(input logic [15:0] pc, input int l, input logic st);
    redirect    = 1'b1;
    redirect_pc = pc;
    lat         = l;
    stall       = st;
    gnt_en      = 1'b1;
    #1 chk("redir_req_low", 32'(imem_req), 32'd0);
    @(negedge clk);
    redirect = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    repeat (2) @(negedge clk);
    chk("rst_instr", 32'(instr), 32'hF000);
    chk("rst_pc_inc", 32'(PC_inc), 32'h0000);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'h0010);

    // First fetch, 1-cycle memory
    gnt_en = 1'b1;
    rst    = 1'b0;
    #1;
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", 32'(imem_addr), 32'h0010);
    repeat (2) @(negedge clk);
    chk("first_instr", 32'(instr), 32'h0123);
    chk("first_pc_inc", 32'(PC_inc), 32'h0011);
    chk("first_valid", 32'(instr_valid), 32'd1);

    // Stall with 3-cycle memory: credits stop fetching at 2 entries
    quiesce();
    redirect_to(16'h0300, 3, 1'b0);
    repeat (4) @(negedge clk);
    chk("stall_pre_instr", 32'(instr), 32'h1300);
    chk("stall_pre_pc", 32'(PC_inc), 32'h0301);
    stall = 1'b1;
    g0    = gcnt;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("stall_hold", 32'(instr), 32'h1300);
    end
    chk("stall_grants", 32'(gcnt - g0), 32'd2);
    chk("stall_req_low", 32'(imem_req), 32'd0);
    stall = 1'b0;
    @(negedge clk);
    chk("stall_e0_instr", 32'(instr), 32'h1301);
    chk("stall_e0_pc", 32'(PC_inc), 32'h0302);
    @(negedge clk);
    chk("stall_e1_instr", 32'(instr), 32'h1302);
    chk("stall_e1_pc", 32'(PC_inc), 32'h0303);

    // Redirect during F_WAIT; stale word arrives the next cycle
    quiesce();
    redirect_to(16'h0100, 3, 1'b0);
    repeat (2) @(negedge clk);
    redirect    = 1'b1;
    redirect_pc = 16'h0200;
    #1 chk("stale_redir_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    redirect = 1'b0;
    #1;
    chk("stale_rvalid_now", 32'(imem_rvalid), 32'd1);
    chk("stale_squash_req", 32'(imem_req), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stale_not_seen", 32'(instr == 16'hAAAA), 32'd0);
      if (i == 0) begin
        chk("stale_next_req", 32'(imem_req), 32'd1);
        chk("stale_next_addr", 32'(imem_addr), 32'h0200);
      end
    end
    chk("stale_new_instr", 32'(instr), 32'h1200);
    chk("stale_new_valid", 32'(instr_valid), 32'd1);

    // Redirect and rvalid in the same cycle
    quiesce();
    redirect_to(16'h0400, 1, 1'b0);
    @(negedge clk);
    redirect    = 1'b1;
    redirect_pc = 16'h0500;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    chk("same_bubble_instr", 32'(instr), 32'hF000);
    chk("same_bubble_valid", 32'(instr_valid), 32'd0);
    chk("same_req", 32'(imem_req), 32'd1);
    chk("same_addr", 32'(imem_addr), 32'h0500);
    @(negedge clk);
    chk("same_empty_instr", 32'(instr), 32'hF000);
    chk("same_empty_valid", 32'(instr_valid), 32'd0);
    @(negedge clk);
    chk("same_next_instr", 32'(instr), 32'h1500);
    chk("same_next_pc", 32'(PC_inc), 32'h0501);

    // Flush with head 0x1234
    quiesce();
    redirect_to(16'h0234, 1, 1'b1);
    repeat (4) @(negedge clk);
    chk("flush_full_req", 32'(imem_req), 32'd0);
    stall = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_bubble_instr", 32'(instr), 32'hF000);
    chk("flush_bubble_valid", 32'(instr_valid), 32'd0);
    flush = 1'b0;
    @(negedge clk);
    chk("flush_head_instr", 32'(instr), 32'h1234);
    chk("flush_head_pc", 32'(PC_inc), 32'h0235);
    chk("flush_head_valid", 32'(instr_valid), 32'd1);
    @(negedge clk);
    chk("flush_second", 32'(instr), 32'h1235);

    // PC wrap at 0xFFFF
    quiesce();
    redirect_to(16'hFFFF, 1, 1'b0);
    chk("wrap_addr", 32'(imem_addr), 32'hFFFF);
    repeat (2) @(negedge clk);
    chk("wrap_instr", 32'(instr), 32'h1FFF);
    chk("wrap_pc_inc", 32'(PC_inc), 32'h0000);
    chk("wrap_next_addr", 32'(imem_addr), 32'h0000);
    chk("wrap_next_req", 32'(imem_req), 32'd1);

    // CALL 0xD345 at 0x2000
    quiesce();
    redirect_to(16'h2000, 1, 1'b0);
    repeat (2) @(negedge clk);
    chk("call_instr", 32'(instr), 32'hD345);
    chk("call_valid", 32'(instr_valid), 32'd1);
`ifdef IF_CALL_PREDECODE_EN
    chk("call_predicted", 32'(call_predicted), 32'd1);
    chk("call_target_addr", 32'(imem_addr), 32'h2345);
    @(negedge clk);
    chk("call_pred_clear", 32'(call_predicted), 32'd0);
`else
    chk("call_seq_addr", 32'(imem_addr), 32'h2001);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
